// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared widths and owner-tag encoding for the memory port arbiter
package mips_mem_pkg;

  localparam int ADDR_W_DFLT = 10;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and single-port memory signals of the arbiter
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // slave: the arbiter; master: requesters plus the memory that answers them
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port memory
// Data port wins by default; fetch is forced through after STARVE_MAX lost cycles.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int STARVE_MAX = 4,
  localparam int SC_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus,
  output logic [SC_W-1:0]  starve_cnt_o
);

  logic [SC_W-1:0]   starve_q, starve_d;
  owner_e            owner_q, owner_d;
  logic              starved, d_win, i_gnt, d_gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  always_comb begin
    starved   = bus.i_req && (starve_q == SC_W'(STARVE_MAX));
    d_win     = bus.d_req && !starved;
    i_gnt     = !rst && bus.i_req && !d_win;
    d_gnt     = !rst && d_win;
    addr_sel  = '0;
    wdata_sel = '0;
    if (i_gnt) begin
      addr_sel = bus.i_addr;
    end else if (d_gnt) begin
      addr_sel = bus.d_addr;
      if (bus.d_we) wdata_sel = bus.d_wdata;
    end

    starve_d = starve_q;
    if (!bus.i_req || i_gnt) starve_d = '0;
    else if (starve_q != SC_W'(STARVE_MAX)) starve_d = starve_q + SC_W'(1);

    // Stores return nothing, so only reads leave an owner for next cycle's response
    owner_d = OWN_NONE;
    if (i_gnt) owner_d = OWN_I;
    else if (d_gnt && !bus.d_we) owner_d = OWN_D;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = i_gnt || d_gnt;
  assign bus.mem_we    = d_gnt && bus.d_we;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;

  assign bus.i_rvalid  = (owner_q == OWN_I);
  assign bus.d_rvalid  = (owner_q == OWN_D);
  assign bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
  assign starve_cnt_o  = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with random and directed traffic
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int STARVE = 4;

  typedef struct {
    bit          port_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  starve_cnt;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_starve = 0;
  exp_t        sb[$];
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .starve_cnt_o (starve_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory: a write is visible to a read issued the following cycle
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    else bus.mem_rdata <= $urandom;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  exp_t e;
  bit   exp_iv, exp_dv;
  logic [31:0] exp_ir, exp_dr;

  always @(negedge clk) begin
    exp_iv = 1'b0; exp_dv = 1'b0; exp_ir = '0; exp_dr = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.port_d) begin exp_dv = 1'b1; exp_dr = e.data; end
      else begin exp_iv = 1'b1; exp_ir = e.data; end
    end
    chk("i_rvalid", bus.i_rvalid, exp_iv);
    chk("d_rvalid", bus.d_rvalid, exp_dv);
    chk("i_rdata", bus.i_rdata, exp_ir);
    chk("d_rdata", bus.d_rdata, exp_dr);
  end

  // Drive one cycle of requests, check the grant against the arbitration rules, queue read responses
  task automatic step(input bit ir, input logic [9:0] ia, input bit dr, input bit dw,
                      input logic [9:0] da, input logic [31:0] dd, output bit ig, output bit dg);
    bit exp_i, exp_d;
    @(negedge clk);
    bus.i_req = ir; bus.i_addr = ia;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    #1;
    exp_i = !rst && ir && (!dr || m_starve == STARVE);
    exp_d = !rst && dr && !exp_i;
    chk("starve_cnt", starve_cnt, m_starve);
    chk("i_gnt", bus.i_gnt, exp_i);
    chk("d_gnt", bus.d_gnt, exp_d);
    chk("mem_en", bus.mem_en, exp_i || exp_d);
    chk("mem_we", bus.mem_we, exp_d && dw);
    if (exp_i) chk("mem_addr_i", bus.mem_addr, ia);
    if (exp_d) chk("mem_addr_d", bus.mem_addr, da);
    if (exp_d && dw) chk("mem_wdata", bus.mem_wdata, dd);
    if (rst) begin
      chk("mem_addr_rst", bus.mem_addr, 0);
      chk("mem_wdata_rst", bus.mem_wdata, 0);
    end
    if (!rst) begin
      if (!ir || exp_i) m_starve = 0;
      else if (m_starve < STARVE) m_starve++;
    end
    if (exp_i) sb.push_back('{port_d: 1'b0, data: ref_mem[ia], due: cyc + 1});
    if (exp_d && !dw) sb.push_back('{port_d: 1'b1, data: ref_mem[da], due: cyc + 1});
    if (exp_d && dw) ref_mem[da] = dd;
    ig = exp_i;
    dg = exp_d;
  endtask

  task automatic idle(input int n);
    bit ig, dg;
    for (int k = 0; k < n; k++) step(0, 10'($urandom), 0, 1'($urandom), 10'($urandom), $urandom, ig, dg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ig, dg, pi, pd, pdw;
    logic [9:0]  pia, pda;
    logic [31:0] pdd;
    logic [5:0]  seq;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'h2801000a;
    ref_mem[5] = 32'h2801000a;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

    step(1, 10'd3, 1, 1, 10'd4, 32'h1234, ig, dg);
    step(1, 10'd3, 1, 0, 10'd4, 32'h0, ig, dg);
    @(posedge clk); #2 rst = 0;

    step(1, 10'd5, 0, 0, 10'd0, 32'h0, ig, dg);
    idle(1);
    chk("fetch5_value", ref_mem[5], 32'h2801000a);

    step(1, 10'd7, 1, 0, 10'd20, 32'h0, ig, dg);
    chk("collision_d_first", {ig, dg}, 2'b01);
    step(1, 10'd7, 0, 0, 10'd20, 32'h0, ig, dg);
    chk("collision_i_next", {ig, dg}, 2'b10);
    idle(1);

    seq = '0;
    pi = 1;
    for (int k = 0; k < 6; k++) begin
      step(pi, 10'd11, 1, 0, 10'(30 + k), 32'h0, ig, dg);
      if (ig) pi = 0;
      seq = {seq[4:0], dg};
    end
    chk("starve_sequence", seq, 6'b111101);
    idle(1);

    step(0, 10'd0, 1, 1, 10'd100, 32'hdeadbeef, ig, dg);
    step(0, 10'd0, 1, 0, 10'd100, 32'h0, ig, dg);
    idle(1);
    chk("store_load_value", ref_mem[100], 32'hdeadbeef);

    step(1, 10'd9, 0, 0, 10'd0, 32'h0, ig, dg);
    @(posedge clk); #1 rst = 1;
    sb.delete();
    m_starve = 0;
    step(1, 10'd9, 1, 0, 10'd2, 32'h0, ig, dg);
    @(posedge clk); #2 rst = 0;
    step(1, 10'd9, 0, 0, 10'd0, 32'h0, ig, dg);
    chk("resume_after_rst", ig, 1'b1);
    idle(1);

    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) step(1, 10'(200 + k), 0, 0, 10'd0, 32'h0, ig, dg);
      else step(0, 10'd0, 1, 0, 10'(300 + k), 32'h0, ig, dg);
    end
    idle(1);

    pi = 0; pd = 0; pdw = 0; pia = 0; pda = 0; pdd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pi && $urandom_range(0, 3) != 0) begin pi = 1; pia = 10'($urandom_range(0, 31)); end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd = 1; pdw = 1'($urandom_range(0, 1)); pda = 10'($urandom_range(0, 31)); pdd = $urandom;
      end
      step(pi, pia, pd, pdw, pda, pdd, ig, dg);
      if (ig) pi = 0;
      if (dg) pd = 0;
      if (!pd) pdw = 1'($urandom_range(0, 1));
    end
    idle(3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width (1024-word memory).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive fetch-lost cycles before fetch is forced to win.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 i_req  in  1  fetch port request (read only); i_addr  in  ADDR_W  fetch word address.
REQ-007 i_gnt  out  1  fetch request accepted this cycle; i_rvalid  out  1  fetch data valid; i_rdata  out  DATA_W  fetch data.
REQ-008 d_req  in  1  data port request; d_we  in  1  1 = store, 0 = load; d_addr  in  ADDR_W  data address; d_wdata  in  DATA_W  store data.
REQ-009 d_gnt  out  1  data request accepted; d_rvalid  out  1  load data valid; d_rdata  out  DATA_W  load data.
REQ-010 mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W: single-port memory command; mem_rdata  in  DATA_W: memory read data, one cycle after mem_en with mem_we=0.

Function
REQ-011 At most one of i_gnt/d_gnt SHALL be high per cycle; grant is combinational from current requests and registered arbitration state.
REQ-012 Requester SHALL hold req/addr/we/wdata stable until gnt; request is consumed in the cycle gnt is high.
REQ-013 Granted request SHALL drive mem_en=1 with its addr/we/wdata in the same cycle; mem_en=0, mem_we=0 when no grant.
REQ-014 Default priority: data port wins when both request.
REQ-015 starve_cnt (width ceil(log2(STARVE_MAX+1))) SHALL increment each cycle i_req=1 and i_gnt=0, clear when i_gnt=1 or i_req=0, and saturate at STARVE_MAX.
REQ-016 When starve_cnt==STARVE_MAX and i_req=1, fetch SHALL win over data that cycle.
REQ-017 Registered owner tag (OWN_NONE, OWN_I, OWN_D) SHALL record the port of each granted read; writes record OWN_NONE.
REQ-018 Read latency exactly 1 cycle: cycle after a granted read, owner's rvalid=1 and rdata=mem_rdata; other port's rvalid=0.
REQ-019 Full throughput: back-to-back grants every cycle SHALL be supported; a read response and a new grant may coincide.
REQ-020 Store grants SHALL produce no rvalid on either port.
REQ-021 Store followed next cycle by load to same address SHALL return the stored data (memory write-first ordering, no arbiter bypass needed).
REQ-022 rdata outputs SHALL be 0 when their rvalid is 0.
REQ-023 d_we is ignored while d_req=0; addresses are used unmodified (no range check, natural ADDR_W wrap).

Reset
REQ-024 On rst: starve_cnt=0, owner=OWN_NONE; i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we =0; rdata outputs, mem_addr, mem_wdata =0.
REQ-025 Grants SHALL be suppressed while rst=1 regardless of requests.
REQ-026 A read granted in the cycle before rst asserts SHALL NOT produce rvalid after rst deasserts.

Structure
REQ-027 Shared package mips_mem_pkg SHALL hold ADDR_W/DATA_W defaults and the owner-tag encoding (OWN_NONE=2'd0, OWN_I=2'd1, OWN_D=2'd2).
REQ-028 Single module; no sub-module (starvation counter and owner tag are inline registers).

Verification
REQ-029 Fetch only: i_req=1, i_addr=5, mem[5]=32'h2801000a -> i_gnt same cycle, i_rvalid=1 and i_rdata=32'h2801000a next cycle, d_rvalid=0.
REQ-030 Collision: i_req=1 and d_req=1 (load, addr 20) same cycle -> d_gnt=1, i_gnt=0; next cycle d_rvalid=1 with mem[20]; fetch granted next cycle if d_req drops.
REQ-031 Starvation: d_req held 1 continuously, i_req=1 -> d_gnt for 4 cycles, i_gnt on cycle 5, starve_cnt back to 0, d_gnt resumes cycle 6.
REQ-032 Store then load: d_we=1, d_addr=100, d_wdata=32'hdeadbeef, then load addr 100 -> no rvalid after store; d_rdata=32'hdeadbeef after load.
REQ-033 Reset mid-read: fetch read granted, rst pulsed next edge -> i_rvalid stays 0, all outputs 0, starve_cnt 0; normal grant resumes after rst deasserts.
REQ-034 Back-to-back: alternating fetch/load every cycle for 8 cycles -> one grant per cycle, each response lands on the correct port exactly 1 cycle later.
